// File: rtl/vc_fifo_bank_pkg.sv
// vc_fifo_bank_pkg: shared widths and thresholds for the demux and vc_fifo_bank stages
package vc_fifo_bank_pkg;
  localparam int def_data_width = 6;
  localparam int def_address_width = 2;
  localparam int def_almost_full = 3;
  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction
endpackage

// File: rtl/vc_fifo_bank_fifo.sv
// vc_fifo: single virtual-channel circular buffer with count-decoded status and sticky drop error
module vc_fifo
  import vc_fifo_bank_pkg::*;
#(
  parameter int data_width = def_data_width,
  parameter int address_width = def_address_width,
  parameter int almost_full_level = def_almost_full
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [data_width-1:0]  data_in,
  output logic [data_width-1:0]  data_out,
  output logic [address_width:0] count,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   error
);
  localparam logic [address_width:0] depth = (address_width+1)'(fifo_depth(address_width));
  logic [data_width-1:0] mem [fifo_depth(address_width)];
  logic [address_width-1:0] wr_ptr, rd_ptr;
  logic pop_ok, accept;
  assign empty = count == '0;
  assign almost_full = count >= (address_width+1)'(almost_full_level);
  assign pop_ok = pop & !empty;
  assign accept = push & (count != depth | pop_ok);
  assign data_out = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (reset && accept) mem[wr_ptr] <= data_in;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      error <= 1'b0;
    end else begin
      wr_ptr <= accept ? wr_ptr + address_width'(1) : wr_ptr;
      rd_ptr <= pop_ok ? rd_ptr + address_width'(1) : rd_ptr;
      count <= (accept & !pop_ok) ? count + (address_width+1)'(1) :
               (!accept & pop_ok) ? count - (address_width+1)'(1) : count;
      error <= error | (push & !accept);
    end
  end
endmodule

// File: rtl/vc_fifo_bank.sv
// vc_fifo_bank: two per-VC FIFOs drained through a fixed-priority (VC0 first) registered output
module vc_fifo_bank
  import vc_fifo_bank_pkg::*;
#(
  parameter int data_width = def_data_width,
  parameter int address_width = def_address_width,
  parameter int almost_full = def_almost_full
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_vc0,
  input  logic                  push_vc1,
  input  logic [data_width-1:0] data_in_vc0,
  input  logic [data_width-1:0] data_in_vc1,
  input  logic                  pause_out,
  output logic [data_width-1:0] data_out,
  output logic                  valid_out,
  output logic                  pause_vc0,
  output logic                  pause_vc1,
  output logic                  empty_vc0,
  output logic                  empty_vc1,
  output logic                  error_vc0,
  output logic                  error_vc1
);
  logic [data_width-1:0] q0, q1;
  logic [address_width:0] count0, count1;
  logic pop0, pop1;
  assign pop0 = !pause_out & count0 != '0;
  assign pop1 = !pause_out & count0 == '0 & count1 != '0;
  vc_fifo #(.data_width(data_width), .address_width(address_width), .almost_full_level(almost_full)) u_fifo0 (
    .clk(clk), .reset(reset), .push(push_vc0), .pop(pop0), .data_in(data_in_vc0), .data_out(q0),
    .count(count0), .empty(empty_vc0), .almost_full(pause_vc0), .error(error_vc0)
  );
  vc_fifo #(.data_width(data_width), .address_width(address_width), .almost_full_level(almost_full)) u_fifo1 (
    .clk(clk), .reset(reset), .push(push_vc1), .pop(pop1), .data_in(data_in_vc1), .data_out(q1),
    .count(count1), .empty(empty_vc1), .almost_full(pause_vc1), .error(error_vc1)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_out <= '0;
      valid_out <= 1'b0;
    end else begin
      data_out <= pop0 ? q0 : pop1 ? q1 : data_out;
      valid_out <= pop0 | pop1;
    end
  end
endmodule
